// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 controller: opcodes, T-state encodings,
// control-word bit positions and the opcode classifier.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int T_W = 6;
    localparam logic [T_W-1:0] T1 = 6'b000001;
    localparam logic [T_W-1:0] T2 = 6'b000010;
    localparam logic [T_W-1:0] T3 = 6'b000100;
    localparam logic [T_W-1:0] T4 = 6'b001000;
    localparam logic [T_W-1:0] T5 = 6'b010000;
    localparam logic [T_W-1:0] T6 = 6'b100000;

    localparam int CW_W         = 12;
    localparam int CW_PC_INC    = 0;
    localparam int CW_PC_EN     = 1;
    localparam int CW_MAR_LATCH = 2;
    localparam int CW_RAM_EN    = 3;
    localparam int CW_IR_LATCH  = 4;
    localparam int CW_IR_EN     = 5;
    localparam int CW_A_LATCH   = 6;
    localparam int CW_A_EN      = 7;
    localparam int CW_B_LATCH   = 8;
    localparam int CW_ALU_EN    = 9;
    localparam int CW_ALU_SUB   = 10;
    localparam int CW_OUT_LATCH = 11;

    typedef logic [CW_W-1:0] ctrl_word_t;

    typedef enum logic [2:0] {
        INS_LDA,
        INS_ADD,
        INS_SUB,
        INS_OUT,
        INS_HLT,
        INS_NOP
    } instr_kind_t;

    function automatic instr_kind_t decode_op(input logic [3:0] op);
        instr_kind_t kind;
        case (op)
            OP_LDA:  kind = INS_LDA;
            OP_ADD:  kind = INS_ADD;
            OP_SUB:  kind = INS_SUB;
            OP_OUT:  kind = INS_OUT;
            OP_HLT:  kind = INS_HLT;
            default: kind = INS_NOP;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring counter with enable, synchronous reset and an
// early-return request that sends the ring straight back to T1.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           early_ret,
    output logic [T_W-1:0] t_state
);

    logic [T_W-1:0] t_state_q;
    logic [T_W-1:0] t_state_d;

    always_comb begin
        t_state_d = t_state_q;
        if (en) begin
            if (early_ret || t_state_q[T_W-1]) begin
                t_state_d = T1;
            end else begin
                t_state_d = {t_state_q[T_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_state_q <= T1;
        end else begin
            t_state_q <= t_state_d;
        end
    end

    assign t_state = t_state_q;

endmodule

// File: rtl/sap_controller.sv
// SAP-1 sequencer: decodes opcode and T-state into the per-cycle control word,
// and freezes the ring in T4 once HLT executes until the next reset.
module sap_controller
    import sap_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [3:0]     instr,
    output logic [T_W-1:0] t_state,
    output logic           halted,
    output logic           pc_inc,
    output logic           pc_en,
    output logic           mar_latch,
    output logic           ram_en,
    output logic           ir_latch,
    output logic           ir_en,
    output logic           a_latch,
    output logic           a_en,
    output logic           b_latch,
    output logic           alu_en,
    output logic           alu_sub,
    output logic           out_latch
);

    logic        halted_q;
    logic        halted_d;
    instr_kind_t kind;
    logic        active;
    logic        halt_now;
    logic        advance;
    logic        early_ret;
    ctrl_word_t  ctrl;

    assign kind     = decode_op(instr);
    assign active   = run && !halted_q;
    assign halt_now = active && t_state[3] && (kind == INS_HLT);
    assign advance  = active && !halt_now;

    // Short-cycle exit points: the last T-state that carries any control.
    assign early_ret = SHORT_CYCLE && ((t_state[2] && kind == INS_NOP) ||
                                       (t_state[3] && kind == INS_OUT) ||
                                       (t_state[4] && kind == INS_LDA));

    sap_ring_counter u_ring (
        .clk       (clk),
        .reset     (reset),
        .en        (advance),
        .early_ret (early_ret),
        .t_state   (t_state)
    );

    always_comb begin
        halted_d = halted_q;
        if (halt_now) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Reset is included in the gate so no partial pulse escapes during the reset cycle.
    always_comb begin
        ctrl = '0;
        if (!reset && active) begin
            if (t_state[0]) begin
                ctrl[CW_PC_EN]     = 1'b1;
                ctrl[CW_MAR_LATCH] = 1'b1;
            end else if (t_state[1]) begin
                ctrl[CW_PC_INC]    = 1'b1;
            end else if (t_state[2]) begin
                ctrl[CW_RAM_EN]    = 1'b1;
                ctrl[CW_IR_LATCH]  = 1'b1;
            end else if (t_state[3]) begin
                if (kind == INS_LDA || kind == INS_ADD || kind == INS_SUB) begin
                    ctrl[CW_IR_EN]     = 1'b1;
                    ctrl[CW_MAR_LATCH] = 1'b1;
                end else if (kind == INS_OUT) begin
                    ctrl[CW_A_EN]      = 1'b1;
                    ctrl[CW_OUT_LATCH] = 1'b1;
                end
            end else if (t_state[4]) begin
                if (kind == INS_LDA) begin
                    ctrl[CW_RAM_EN]  = 1'b1;
                    ctrl[CW_A_LATCH] = 1'b1;
                end else if (kind == INS_ADD || kind == INS_SUB) begin
                    ctrl[CW_RAM_EN]  = 1'b1;
                    ctrl[CW_B_LATCH] = 1'b1;
                end
            end else if (t_state[5]) begin
                if (kind == INS_ADD || kind == INS_SUB) begin
                    ctrl[CW_ALU_EN]  = 1'b1;
                    ctrl[CW_A_LATCH] = 1'b1;
                end
            end
            // Subtract select held across T4..T6 so the ALU has settled by T6.
            if ((kind == INS_SUB) && (t_state[3] || t_state[4] || t_state[5])) begin
                ctrl[CW_ALU_SUB] = 1'b1;
            end
        end
    end

    assign halted    = halted_q;
    assign pc_inc    = ctrl[CW_PC_INC];
    assign pc_en     = ctrl[CW_PC_EN];
    assign mar_latch = ctrl[CW_MAR_LATCH];
    assign ram_en    = ctrl[CW_RAM_EN];
    assign ir_latch  = ctrl[CW_IR_LATCH];
    assign ir_en     = ctrl[CW_IR_EN];
    assign a_latch   = ctrl[CW_A_LATCH];
    assign a_en      = ctrl[CW_A_EN];
    assign b_latch   = ctrl[CW_B_LATCH];
    assign alu_en    = ctrl[CW_ALU_EN];
    assign alu_sub   = ctrl[CW_ALU_SUB];
    assign out_latch = ctrl[CW_OUT_LATCH];

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: a full-cycle and a short-cycle instance run side by
// side against a step-count reference model, directed scenarios then random.
module tb_sap_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [3:0] instr = 4'h0;

    always #5 clk = ~clk;

    // Bench-side control word order, MSB first:
    // pc_en pc_inc mar_latch ram_en ir_latch ir_en a_latch a_en b_latch alu_en alu_sub out_latch
    localparam int B_PC_EN = 11, B_PC_INC = 10, B_MAR = 9, B_RAM_EN = 8, B_IR_LATCH = 7,
                   B_IR_EN = 6, B_A_LATCH = 5, B_A_EN = 4, B_B_LATCH = 3, B_ALU_EN = 2,
                   B_ALU_SUB = 1, B_OUT = 0;

    logic [5:0]  ts0, ts1;
    logic        hl0, hl1;
    logic [11:0] cw0, cw1;

    sap_controller #(.SHORT_CYCLE(1'b0)) dut_full (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .t_state(ts0), .halted(hl0),
        .pc_inc(cw0[B_PC_INC]), .pc_en(cw0[B_PC_EN]), .mar_latch(cw0[B_MAR]),
        .ram_en(cw0[B_RAM_EN]), .ir_latch(cw0[B_IR_LATCH]), .ir_en(cw0[B_IR_EN]),
        .a_latch(cw0[B_A_LATCH]), .a_en(cw0[B_A_EN]), .b_latch(cw0[B_B_LATCH]),
        .alu_en(cw0[B_ALU_EN]), .alu_sub(cw0[B_ALU_SUB]), .out_latch(cw0[B_OUT])
    );

    sap_controller #(.SHORT_CYCLE(1'b1)) dut_short (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .t_state(ts1), .halted(hl1),
        .pc_inc(cw1[B_PC_INC]), .pc_en(cw1[B_PC_EN]), .mar_latch(cw1[B_MAR]),
        .ram_en(cw1[B_RAM_EN]), .ir_latch(cw1[B_IR_LATCH]), .ir_en(cw1[B_IR_EN]),
        .a_latch(cw1[B_A_LATCH]), .a_en(cw1[B_A_EN]), .b_latch(cw1[B_B_LATCH]),
        .alu_en(cw1[B_ALU_EN]), .alu_sub(cw1[B_ALU_SUB]), .out_latch(cw1[B_OUT])
    );

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // Reference model: T-state as a step number 1..6 and a halted flag per instance.
    int step_m [2] = '{1, 1};
    bit halt_m [2] = '{1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle_no, obs, exp);
        end
    endtask

    // Last step of each opcode when short cycles are enabled; 0 = runs to T6.
    function automatic int short_last(input logic [3:0] op);
        if (op == 4'h0) return 5;
        if (op == 4'hE) return 4;
        if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 0;
        return 3;
    endfunction

    function automatic logic [11:0] exp_cw(input logic [3:0] op, input int step);
        logic [11:0] c;
        logic        arith;
        c = '0;
        arith = (op == 4'h1) || (op == 4'h2);
        case (step)
            1: begin c[B_PC_EN] = 1'b1; c[B_MAR] = 1'b1; end
            2: c[B_PC_INC] = 1'b1;
            3: begin c[B_RAM_EN] = 1'b1; c[B_IR_LATCH] = 1'b1; end
            4: begin
                if (op == 4'h0 || arith) begin c[B_IR_EN] = 1'b1; c[B_MAR] = 1'b1; end
                if (op == 4'hE) begin c[B_A_EN] = 1'b1; c[B_OUT] = 1'b1; end
            end
            5: begin
                if (op == 4'h0) begin c[B_RAM_EN] = 1'b1; c[B_A_LATCH] = 1'b1; end
                if (arith) begin c[B_RAM_EN] = 1'b1; c[B_B_LATCH] = 1'b1; end
            end
            6: if (arith) begin c[B_ALU_EN] = 1'b1; c[B_A_LATCH] = 1'b1; end
            default: c = '0;
        endcase
        if (op == 4'h2 && step >= 4) c[B_ALU_SUB] = 1'b1;
        return c;
    endfunction

    task automatic check_inst(input int k, input logic [5:0] ts, input logic hl, input logic [11:0] cw);
        logic [11:0] exp;
        logic [4:0]  drivers;
        exp = (reset || !run || halt_m[k]) ? 12'h000 : exp_cw(instr, step_m[k]);
        drivers = {cw[B_PC_EN], cw[B_RAM_EN], cw[B_IR_EN], cw[B_A_EN], cw[B_ALU_EN]};
        check_eq(k == 0 ? "t_state_full" : "t_state_short", 32'(ts), 32'(1 << (step_m[k] - 1)));
        check_eq(k == 0 ? "halted_full" : "halted_short", 32'(hl), 32'(halt_m[k]));
        check_eq(k == 0 ? "ctrl_full" : "ctrl_short", 32'(cw), 32'(exp));
        check_eq(k == 0 ? "onehot_full" : "onehot_short", 32'($countones(ts)), 32'd1);
        check_eq(k == 0 ? "busdrv_full" : "busdrv_short", 32'($countones(drivers) <= 1), 32'd1);
    endtask

    task automatic model_step(input int k, input int sc);
        int last;
        if (reset) begin
            step_m[k] = 1;
            halt_m[k] = 1'b0;
        end else if (run && !halt_m[k]) begin
            last = (sc != 0) ? short_last(instr) : 0;
            if (instr == 4'hF && step_m[k] == 4) halt_m[k] = 1'b1;
            else if (step_m[k] == 6 || step_m[k] == last) step_m[k] = 1;
            else step_m[k] = step_m[k] + 1;
        end
    endtask

    task automatic do_cycle(input logic r, input logic rn, input logic [3:0] op);
        @(negedge clk);
        reset = r;
        run = rn;
        instr = op;
        #1;
        check_inst(0, ts0, hl0, cw0);
        check_inst(1, ts1, hl1, cw1);
        $display("cyc %0d rst=%b run=%b op=%h | full t=%h h=%b cw=%h | short t=%h h=%b cw=%h",
                 cycle_no, r, rn, op, ts0, hl0, cw0, ts1, hl1, cw1);
        @(posedge clk);
        model_step(0, 0);
        model_step(1, 1);
        cycle_no++;
    endtask

    task automatic repeat_cycle(input int n, input logic r, input logic rn, input logic [3:0] op);
        for (int i = 0; i < n; i++) do_cycle(r, rn, op);
    endtask

    initial begin
        logic [3:0] op_r;
        logic       run_r;
        logic       rst_r;

        repeat_cycle(2, 1'b1, 1'b0, 4'h0);
        repeat_cycle(7, 1'b0, 1'b1, 4'h0);           // LDA, full ring plus wrap
        repeat_cycle(1, 1'b1, 1'b1, 4'h0);
        repeat_cycle(6, 1'b0, 1'b1, 4'h1);           // ADD then SUB back to back
        repeat_cycle(6, 1'b0, 1'b1, 4'h2);
        repeat_cycle(1, 1'b1, 1'b1, 4'h0);
        repeat_cycle(6, 1'b0, 1'b1, 4'hE);           // OUT
        repeat_cycle(1, 1'b1, 1'b1, 4'h0);
        repeat_cycle(6, 1'b0, 1'b1, 4'h5);           // NOP
        repeat_cycle(1, 1'b1, 1'b1, 4'h0);
        repeat_cycle(4, 1'b0, 1'b1, 4'h1);           // ADD paused in T5
        repeat_cycle(3, 1'b0, 1'b0, 4'h1);
        repeat_cycle(3, 1'b0, 1'b1, 4'h1);
        repeat_cycle(1, 1'b1, 1'b1, 4'h0);
        repeat_cycle(26, 1'b0, 1'b1, 4'hF);          // HLT freeze
        repeat_cycle(1, 1'b1, 1'b1, 4'hF);
        repeat_cycle(4, 1'b0, 1'b1, 4'h0);
        repeat_cycle(1, 1'b1, 1'b1, 4'h0);           // reset mid-instruction
        repeat_cycle(3, 1'b0, 1'b1, 4'h2);

        op_r = 4'h0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) op_r = 4'($urandom_range(0, 15));
            run_r = ($urandom_range(0, 99) < 85);
            rst_r = ($urandom_range(0, 199) == 0);
            do_cycle(rst_r, run_r, op_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
